// File: rtl/jkseq_pkg.sv
// JK sequencer shared types: op encodings, FIFO sizing and FSM states.
// Build option: JKSEQ_CHECK_EN enables the y_in/y_exp mismatch checker.
package jkseq_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int REP_W      = 4;
  localparam int OP_W       = 2;
  localparam int CMD_W      = OP_W + REP_W;

  // Bit 1 drives j, bit 0 drives k.
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DRAIN = 2'b10
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [REP_W-1:0] rep;
  } cmd_t;

  function automatic logic next_jk(
    input logic j,
    input logic k,
    input logic y
  );
    logic r;
    r = y;
    unique case ({j, k})
      2'b10:   r = 1'b1;
      2'b01:   r = 1'b0;
      2'b11:   r = ~y;
      default: r = y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jkseq_fifo.sv
// 4-deep command FIFO for the JK sequencer; caller never pushes when full
// nor pops when empty.
module jkseq_fifo
  import jkseq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  cmd_t wdata_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/jk_seq_ctrl.sv
// Queued JK-cell command sequencer with predicted state and optional
// mismatch checker (JKSEQ_CHECK_EN).
module jk_seq_ctrl
  import jkseq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [REP_W-1:0] cmd_rep,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  input  logic             y_in,
  output logic             y_exp,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             y_q, y_d;
  logic             push, pop, load;
  logic             full, empty;
  cmd_t             head;

  assign push = cmd_valid & ~full;

  jkseq_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cmd_t'({cmd_op, cmd_rep})),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: load = ~empty;
      S_ISSUE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          j_d   = j_q;
          k_d   = k_q;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Back-to-back reload keeps the FSM in ISSUE with no bubble.
    if (load) begin
      pop     = 1'b1;
      state_d = S_ISSUE;
      cnt_d   = head.rep;
      j_d     = head.op[1];
      k_d     = head.op[0];
    end
  end

  assign y_d = next_jk(j_q, k_q, y_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      y_q     <= y_d;
    end
  end

`ifdef JKSEQ_CHECK_EN
  logic chk_q;
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      chk_q <= j_q | k_q;
      err_q <= err_q | (chk_q & (y_in != y_q));
    end
  end

  assign err = err_q;
`else
  logic unused_y_in;
  assign unused_y_in = y_in;
  assign err = 1'b0;
`endif

  assign cmd_ready = ~full;
  assign j         = j_q;
  assign k         = k_q;
  assign y_exp     = y_q;
  assign busy      = (state_q != S_IDLE) | ~empty;
  assign done      = (state_q == S_DRAIN);

endmodule

// File: doc/jk_seq_ctrl.md
JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-low reset; shared with the controlled JK cell.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_op  in  2  00 hold, 01 clear (k), 10 set (j), 11 toggle (j,k).
REQ-006 cmd_rep  in  4  issue count minus one (0 to 15 gives 1 to 16 cycles).
REQ-007 cmd_ready  out  1  command FIFO not full.
REQ-008 j, k  out  1 each  registered drive to the JK cell.
REQ-009 y_in  in  1  registered output of the JK cell.
REQ-010 y_exp  out  1  predicted JK state.
REQ-011 busy  out  1  state is not IDLE, or the FIFO is not empty.
REQ-012 done  out  1  one-cycle pulse when the last queued command completes.
REQ-013 err  out  1  sticky mismatch between y_in and y_exp.

Function
REQ-014 A command SHALL be accepted on a clock edge where cmd_valid and cmd_ready are both 1, and pushed into a 4-entry FIFO.
REQ-015 cmd_ready SHALL be 0 while the FIFO holds 4 entries, even if a pop occurs in the same cycle.
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-017 In IDLE with a non-empty FIFO, the next edge SHALL pop an entry, load the op/count register, drive j/k and enter ISSUE.
REQ-018 Latency: j/k for a command accepted into an empty FIFO in IDLE SHALL first appear one edge after the acceptance edge.
REQ-019 ISSUE SHALL hold j/k for exactly cmd_rep+1 cycles, decrementing the counter each cycle.
REQ-020 On the last ISSUE cycle with a non-empty FIFO, the block SHALL pop the next command with no bubble and stay in ISSUE.
REQ-021 On the last ISSUE cycle with an empty FIFO, the block SHALL enter DRAIN with j=k=0.
REQ-022 DRAIN SHALL last one cycle, pulse done, and then enter IDLE.
REQ-023 In IDLE and DRAIN, j and k SHALL both be 0.
REQ-024 y_exp SHALL update on every edge from the current j/k: 10 gives 1, 01 gives 0, 11 gives ~y_exp, 00 holds.
REQ-025 The check SHALL run in each cycle that follows a cycle with j or k asserted, comparing y_in with y_exp.
REQ-026 A mismatch SHALL set err, which stays 1 until reset.
REQ-027 A cmd_rep of 15 SHALL issue 16 cycles, and the 4-bit counter SHALL NOT wrap.

Reset
REQ-028 While rst=0, the block SHALL empty the FIFO and set state=IDLE, j=k=0, y_exp=0, done=0, err=0, busy=0 and cmd_ready=1, asynchronously.
REQ-029 Reset asserted mid-ISSUE SHALL abort the current command and discard all queued commands.

Configuration
REQ-030 With JKSEQ_CHECK_EN defined, the mismatch checker of REQ-025 and REQ-026 SHALL be built in.
REQ-031 With JKSEQ_CHECK_EN undefined, err SHALL be tied to 0 and no compare logic SHALL be built; y_exp SHALL still be produced.

Structure
REQ-032 The package jkseq_pkg SHALL hold the op encodings, FIFO_DEPTH=4, REP_W=4 and the FSM state encoding.
REQ-033 The FIFO SHALL be a sub-module named jkseq_fifo, 6 bits wide and 4 entries deep, with full/empty outputs.

Verification
REQ-034 Set (10) with rep=2, then idle: j=1,k=0 for 3 cycles; y_in=1 one edge after the first issue edge; done pulses once; err=0.
REQ-035 Back-to-back set rep=0, toggle rep=3, clear rep=0: no idle cycle between the commands; y_exp sequence 1,0,1,0,1,0.
REQ-036 Push 5 commands while stalled in ISSUE rep=15: cmd_ready=0 after the 4th push; the 5th is held until a pop.
REQ-037 Force y_in opposite to y_exp for one cycle after a set: err=1 and stays 1; with the macro undefined, err=0.
REQ-038 Assert rst mid-ISSUE with 2 commands queued: j=k=0, busy=0 and y_exp=0 immediately; no command issues after release.
